// File: rtl/mul_pkg.sv
// Shared definitions for the memory-mapped multiplier: sequencer state encoding,
// buffer geometry defaults and bus slave register offsets.
package mul_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int AW_DEF    = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_WR_LO  = 3'd4,
        ST_WR_HI  = 3'd5,
        ST_DONE   = 3'd6
    } seq_state_e;

    // Bus slave register map (word offsets)
    localparam logic [3:0] REG_CAND   = 4'h0;
    localparam logic [3:0] REG_LIER   = 4'h1;
    localparam logic [3:0] REG_START  = 4'h2;
    localparam logic [3:0] REG_CLEAR  = 4'h3;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_RADDR  = 4'h5;
    localparam logic [3:0] REG_RDATA  = 4'h6;

endpackage

// File: rtl/pair_counter.sv
// Saturating 0..DEPTH occupancy counter for one operand buffer.
module pair_counter #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] count
);

    // Count accepted strobes, holding at DEPTH; clear wins over enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count < CW'(DEPTH))) begin
            count <= count + CW'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// Walks buffered operand pairs through a multi-cycle multiplier core and writes
// each 64-bit product to the result memory as low word then high word.
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          opstart,
    input  logic          opclear,
    input  logic          cand_we,
    input  logic          lier_we,
    output logic [AW-1:0] cand_waddr,
    output logic [AW-1:0] lier_waddr,
    output logic [AW-1:0] op_raddr,
    output logic          mul_start,
    input  logic          mul_done,
    input  logic [63:0]   product,
    output logic          res_we,
    output logic [AW:0]   res_waddr,
    output logic [31:0]   res_wdata,
    output logic          opdone,
    output logic [2:0]    seq_state
);

    localparam int CW = AW + 1;

    seq_state_e    state_r;
    logic [AW-1:0] idx_r;
    logic [CW-1:0] n_pairs_r;
    logic [63:0]   product_r;
    logic [CW-1:0] cand_cnt_s;
    logic [CW-1:0] lier_cnt_s;
    logic [CW-1:0] n_avail_s;
    logic          is_idle_s;
    logic          last_pair_s;

    assign is_idle_s   = (state_r == ST_IDLE);
    assign n_avail_s   = (cand_cnt_s < lier_cnt_s) ? cand_cnt_s : lier_cnt_s;
    assign last_pair_s = (n_pairs_r == ({1'b0, idx_r} + {{AW{1'b0}}, 1'b1}));

    pair_counter #(.DEPTH(DEPTH), .CW(CW)) u_cand_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (cand_we && is_idle_s),
        .clr     (opclear),
        .count   (cand_cnt_s)
    );

    pair_counter #(.DEPTH(DEPTH), .CW(CW)) u_lier_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (lier_we && is_idle_s),
        .clr     (opclear),
        .count   (lier_cnt_s)
    );

    // A saturated count wraps the low bits; the slave must not write then.
    assign cand_waddr = cand_cnt_s[AW-1:0];
    assign lier_waddr = lier_cnt_s[AW-1:0];
    assign seq_state  = state_r;

    // Sequencer FSM; outputs are loaded on entry to the state that owns them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            n_pairs_r <= '0;
            product_r <= 64'd0;
            op_raddr  <= '0;
            mul_start <= 1'b0;
            res_we    <= 1'b0;
            res_waddr <= '0;
            res_wdata <= 32'd0;
            opdone    <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            res_we    <= 1'b0;
            if (opclear) begin
                state_r   <= ST_IDLE;
                idx_r     <= '0;
                n_pairs_r <= '0;
                op_raddr  <= '0;
                res_waddr <= '0;
                res_wdata <= 32'd0;
                opdone    <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (opstart) begin
                            n_pairs_r <= n_avail_s;
                            idx_r     <= '0;
                            op_raddr  <= '0;
                            if (n_avail_s != '0) begin
                                state_r <= ST_FETCH;
                            end else begin
                                state_r <= ST_DONE;
                                opdone  <= 1'b1;
                            end
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_FETCH: begin
                        state_r   <= ST_LAUNCH;
                        mul_start <= 1'b1;
                    end
                    ST_LAUNCH: begin
                        state_r <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (mul_done) begin
                            product_r <= product;
                            res_we    <= 1'b1;
                            res_waddr <= {idx_r, 1'b0};
                            res_wdata <= product[31:0];
                            state_r   <= ST_WR_LO;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end
                    ST_WR_LO: begin
                        res_we    <= 1'b1;
                        res_waddr <= {idx_r, 1'b1};
                        res_wdata <= product_r[63:32];
                        state_r   <= ST_WR_HI;
                    end
                    ST_WR_HI: begin
                        if (last_pair_s) begin
                            state_r <= ST_DONE;
                            opdone  <= 1'b1;
                        end else begin
                            idx_r    <= idx_r + AW'(1);
                            op_raddr <= idx_r + AW'(1);
                            state_r  <= ST_FETCH;
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_DONE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer with a latency-programmable core model,
// operand buffers and a result-write log.
module tb_mul_sequencer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        opstart = 1'b0;
    logic        opclear = 1'b0;
    logic        cand_we = 1'b0;
    logic        lier_we = 1'b0;
    logic [2:0]  cand_waddr;
    logic [2:0]  lier_waddr;
    logic [2:0]  op_raddr;
    logic        mul_start;
    logic        mul_done;
    logic [63:0] product;
    logic        res_we;
    logic [3:0]  res_waddr;
    logic [31:0] res_wdata;
    logic        opdone;
    logic [2:0]  seq_state;

    int checks = 0;
    int failures = 0;

    // Environment: operand buffers, core model, result log
    logic [31:0] cand_mem [DEPTH];
    logic [31:0] lier_mem [DEPTH];
    int          mc = 0;
    int          ml = 0;
    int          core_lat = 4;
    logic [31:0] rd_c = 32'd0;
    logic [31:0] rd_l = 32'd0;
    logic [63:0] prod_r = 64'd0;
    int          core_cnt = 0;
    logic        done_r = 1'b0;
    logic        inj_done = 1'b0;
    logic [3:0]  wq_addr [$];
    logic [31:0] wq_data [$];

    always #5 clk = ~clk;

    mul_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opstart    (opstart),
        .opclear    (opclear),
        .cand_we    (cand_we),
        .lier_we    (lier_we),
        .cand_waddr (cand_waddr),
        .lier_waddr (lier_waddr),
        .op_raddr   (op_raddr),
        .mul_start  (mul_start),
        .mul_done   (mul_done),
        .product    (product),
        .res_we     (res_we),
        .res_waddr  (res_waddr),
        .res_wdata  (res_wdata),
        .opdone     (opdone),
        .seq_state  (seq_state)
    );

    assign mul_done = done_r | inj_done;
    assign product  = done_r ? prod_r : 64'hDEAD_BEEF_0BAD_F00D;

    always @(posedge clk) begin
        rd_c <= cand_mem[op_raddr];
        rd_l <= lier_mem[op_raddr];
        if (mul_start) begin
            prod_r   <= 64'(rd_c) * 64'(rd_l);
            core_cnt <= core_lat - 1;
            done_r   <= (core_lat == 1);
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            done_r   <= (core_cnt == 1);
        end else begin
            done_r <= 1'b0;
        end
        if (res_we) begin
            wq_addr.push_back(res_waddr);
            wq_data.push_back(res_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mul_start"}, 64'(mul_start), 64'd0);
        check({tag, "_res_we"}, 64'(res_we), 64'd0);
        check({tag, "_res_waddr"}, 64'(res_waddr), 64'd0);
        check({tag, "_res_wdata"}, 64'(res_wdata), 64'd0);
        check({tag, "_opdone"}, 64'(opdone), 64'd0);
        check({tag, "_op_raddr"}, 64'(op_raddr), 64'd0);
        check({tag, "_cand_waddr"}, 64'(cand_waddr), 64'd0);
        check({tag, "_lier_waddr"}, 64'(lier_waddr), 64'd0);
        check({tag, "_seq_state"}, 64'(seq_state), 64'd0);
    endtask

    // Slave write of one operand and/or multiplier; full buffers drop the data.
    task automatic wr(input bit c, input bit l, input logic [31:0] a, input logic [31:0] b);
        if (c && mc < DEPTH) begin
            check("cand_waddr", 64'(cand_waddr), 64'(mc));
            cand_mem[mc] = a;
            mc++;
        end
        if (l && ml < DEPTH) begin
            check("lier_waddr", 64'(lier_waddr), 64'(ml));
            lier_mem[ml] = b;
            ml++;
        end
        cand_we = c;
        lier_we = l;
        tick();
        cand_we = 1'b0;
        lier_we = 1'b0;
    endtask

    task automatic do_clear();
        opclear = 1'b1;
        tick();
        opclear = 1'b0;
        mc = 0;
        ml = 0;
    endtask

    // Start a run and check completion time and every result word written.
    task automatic run_check(input int lat, input bit hold);
        int n;
        int cyc;
        logic [63:0] p;
        n = (mc < ml) ? mc : ml;
        core_lat = lat;
        wq_addr.delete();
        wq_data.delete();
        opstart = 1'b1;
        tick();
        if (!hold) opstart = 1'b0;
        cyc = 0;
        while (!opdone && cyc < 3000) begin
            tick();
            cyc++;
        end
        check("opdone_latency", 64'(cyc + 1), 64'(1 + n * (4 + lat)));
        check("write_count", 64'(wq_addr.size()), 64'(2 * n));
        for (int i = 0; i < n && 2 * i + 1 < wq_addr.size(); i++) begin
            p = 64'(cand_mem[i]) * 64'(lier_mem[i]);
            check("res_addr_lo", 64'(wq_addr[2*i]), 64'(2 * i));
            check("res_data_lo", 64'(wq_data[2*i]), 64'(p[31:0]));
            check("res_addr_hi", 64'(wq_addr[2*i+1]), 64'(2 * i + 1));
            check("res_data_hi", 64'(wq_data[2*i+1]), 64'(p[63:32]));
        end
    endtask

    initial begin
        int n;
        int cyc;
        int lat;
        logic [31:0] fixed_words [6];

        // Reset state
        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();
        check_all_zero("post_reset");

        // Directed: three pairs, L=4
        wr(1'b1, 1'b1, 32'd3, 32'd5);
        wr(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2);
        wr(1'b1, 1'b1, 32'd7, 32'd0);
        run_check(4, 1'b0);
        fixed_words[0] = 32'd15;
        fixed_words[1] = 32'd0;
        fixed_words[2] = 32'hFFFF_FFFE;
        fixed_words[3] = 32'd1;
        fixed_words[4] = 32'd0;
        fixed_words[5] = 32'd0;
        for (int i = 0; i < 6 && i < wq_data.size(); i++)
            check("fixed_word", 64'(wq_data[i]), 64'(fixed_words[i]));
        check("done_state", 64'(seq_state), 64'd6);
        do_clear();
        check("clear_opdone", 64'(opdone), 64'd0);
        check("clear_state", 64'(seq_state), 64'd0);

        // Start with no operands: straight to DONE, nothing written
        run_check(3, 1'b0);
        check("empty_state", 64'(seq_state), 64'd6);
        do_clear();
        check_all_zero("empty_clear");

        // Saturation: nine strobes on each buffer
        for (int i = 0; i < 9; i++) wr(1'b1, 1'b1, $urandom, $urandom);
        run_check($urandom_range(1, 6), 1'b0);
        do_clear();

        // Randomized runs
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) wr(1'b1, 1'b1, $urandom, $urandom);
            if (r == 1) wr(1'b1, 1'b0, $urandom, 32'd0);
            if (r == 2) wr(1'b0, 1'b1, 32'd0, $urandom);
            run_check($urandom_range(1, 6), 1'b0);
            do_clear();
        end

        // Abort during WAIT of pair 1; late and stray mul_done ignored
        for (int i = 0; i < 3; i++) wr(1'b1, 1'b1, $urandom, $urandom);
        core_lat = 8;
        wq_addr.delete();
        wq_data.delete();
        opstart = 1'b1;
        tick();
        opstart = 1'b0;
        cyc = 0;
        while (!(seq_state == 3'd3 && op_raddr == 3'd1) && cyc < 200) begin
            tick();
            cyc++;
        end
        check("reach_wait1", 64'(cyc < 200), 64'd1);
        do_clear();
        check_all_zero("abort");
        repeat (12) tick();
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        tick();
        check("abort_idle", 64'(seq_state), 64'd0);
        check("abort_writes", 64'(wq_addr.size()), 64'd2);
        run_check(3, 1'b0);
        do_clear();
        for (int i = 0; i < 2; i++) wr(1'b1, 1'b1, $urandom, $urandom);
        run_check($urandom_range(1, 6), 1'b0);
        do_clear();

        // Reset during WR_LO
        wr(1'b1, 1'b1, $urandom, $urandom);
        core_lat = 2;
        wq_addr.delete();
        wq_data.delete();
        opstart = 1'b1;
        tick();
        opstart = 1'b0;
        cyc = 0;
        while (seq_state != 3'd4 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("reach_wr_lo", 64'(cyc < 200), 64'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (3) tick();
        reset_n = 1'b1;
        mc = 0;
        ml = 0;
        tick();
        check_all_zero("mid_reset_release");
        check("mid_reset_writes", 64'(wq_addr.size()), 64'd0);

        // opstart held through the run and in DONE
        for (int i = 0; i < 2; i++) wr(1'b1, 1'b1, $urandom, $urandom);
        lat = $urandom_range(1, 6);
        run_check(lat, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_opdone", 64'(opdone), 64'd1);
        end
        check("hold_state", 64'(seq_state), 64'd6);
        check("hold_no_rewrite", 64'(wq_addr.size()), 64'd4);
        cand_we = 1'b1;
        tick();
        cand_we = 1'b0;
        tick();
        check("done_cand_waddr", 64'(cand_waddr), 64'd2);
        opstart = 1'b0;
        do_clear();
        check("final_idle", 64'(seq_state), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
